seq_detect_param: RTL
=====================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, 8, pattern length in bits (2..32).
REQ-002 Parameter CNT_W, 16, width of the match counter.
REQ-003 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 D_IN  in  1  serial data bit.
REQ-006 D_VALID  in  1  D_IN sampled only when high.
REQ-007 PAT_LOAD  in  1  one-cycle strobe: load PAT_IN/MASK_IN.
REQ-008 PAT_IN  in  PAT_LEN  target pattern; bit PAT_LEN-1 is the oldest bit, bit 0 the newest.
REQ-009 MASK_IN  in  PAT_LEN  per-bit don't-care; 1 means ignore that position.
REQ-010 OVERLAP  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 MATCH  out  1  registered one-cycle match pulse.
REQ-012 MATCH_CNT  out  CNT_W  saturating count of matches.
REQ-013 ARMED  out  1  high when at least PAT_LEN valid bits are held since the last clear.

Function
REQ-014 On posedge with D_VALID=1 and PAT_LOAD=0: history <= {history[PAT_LEN-2:0], D_IN}, and fill increments, saturating at PAT_LEN.
REQ-015 A hit occurs when the next-state fill equals PAT_LEN and (next history XOR pattern) AND NOT mask equals 0.
REQ-016 MATCH is registered and goes high on the same posedge that samples the completing bit; it stays high exactly one cycle.
REQ-017 When D_VALID=0: history, fill and MATCH_CNT hold, and MATCH goes 0 on that edge.
REQ-018 OVERLAP=1: fill is unchanged after a hit, so consecutive matches may share bits.
REQ-019 OVERLAP=0: fill is cleared to 0 on a hit, so the next match requires PAT_LEN fresh valid bits.
REQ-020 OVERLAP is sampled every edge; a mid-stream change affects only subsequent hits.
REQ-021 PAT_LOAD=1 loads the pattern and mask registers and clears fill, MATCH and MATCH_CNT; history keeps its contents.
REQ-022 If D_VALID=1 on the PAT_LOAD edge, that bit is discarded; PAT_LOAD has priority.
REQ-023 On each hit, MATCH_CNT increments by 1 and saturates at 2^CNT_W-1 (no wrap).
REQ-024 With an all-ones mask, every valid bit produces a hit once ARMED (OVERLAP=1).
REQ-025 ARMED is a registered output equal to (fill == PAT_LEN).

Reset
REQ-026 RST has priority over PAT_LOAD and D_VALID.
REQ-027 On RST: history=0, fill=0, pattern=0, mask=0, MATCH=0, MATCH_CNT=0, ARMED=0.
REQ-028 RST asserted mid-stream discards partial history; no MATCH on the first edge after RST deasserts.

Structure
REQ-029 Package seq_pkg holds the PAT_LEN/CNT_W default constants and the fill-counter width function clog2(PAT_LEN+1).
REQ-030 The history is one sub-module, shift_reg_n (parameter N, ports CLK, RST, EN, D, Q), instantiated as u_sr so that u_sr.Q is dumpable.
REQ-031 The compare is combinational on next-state history; every output is a direct flop output.

Verification (PAT_LEN=4, pattern 1011, mask 0000 unless noted)
REQ-032 RST high 4 cycles with stream active -> MATCH=0, MATCH_CNT=0, ARMED=0 throughout.
REQ-033 OVERLAP=1, valid stream 1011011 -> MATCH pulses on bits 4 and 7; MATCH_CNT=2.
REQ-034 OVERLAP=0, same stream -> MATCH only on bit 4; MATCH_CNT=1; ARMED drops after bit 4.
REQ-035 Stream 1,0,(D_VALID=0 for 3 cycles),1,1 -> MATCH=0 during the gap; single MATCH on the final bit.
REQ-036 Mask 0100, stream 1111 -> MATCH on bit 4; then PAT_LOAD with bit 1 valid -> MATCH_CNT=0, ARMED=0, bit ignored.
REQ-037 CNT_W=2, five matches -> MATCH_CNT=3; RST after 101 then bit 1 -> no MATCH.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared defaults and helpers for the serial pattern detector.
package seq_pkg;

    localparam int PAT_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 16;

    // Bits needed to encode values 0..value-1; never returns less than 1.
    function automatic int clog2(input int unsigned value);
        int          r;
        int unsigned v;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/shift_reg_n.sv
// Serial-in shift register holding the most recent N sampled bits.
// Bit 0 is the newest bit, bit N-1 the oldest.
module shift_reg_n
    import seq_pkg::*;
#(
    parameter int N = PAT_LEN_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         D,
    output logic [N-1:0] Q
);

    // Shift the new bit in at the LSB whenever enabled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else if (EN) begin
            Q <= {Q[N-2:0], D};
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with per-bit don't-care mask, selectable
// overlapping/non-overlapping detection and a saturating match counter.
// The compare looks at the next-state history so MATCH lands on the same
// edge that samples the completing bit.
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int PAT_LEN = PAT_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               D_IN,
    input  logic               D_VALID,
    input  logic               PAT_LOAD,
    input  logic [PAT_LEN-1:0] PAT_IN,
    input  logic [PAT_LEN-1:0] MASK_IN,
    input  logic               OVERLAP,
    output logic               MATCH,
    output logic [CNT_W-1:0]   MATCH_CNT,
    output logic               ARMED
);

    localparam int                FILL_W    = clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_LEN-1:0] hist_q;
    logic [PAT_LEN-1:0] hist_d;
    logic [PAT_LEN-1:0] pat_q,   pat_d;
    logic [PAT_LEN-1:0] mask_q,  mask_d;
    logic [FILL_W-1:0]  fill_q,  fill_d;
    logic [FILL_W-1:0]  fill_inc;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               match_q, match_d;
    logic               armed_q, armed_d;
    logic               shift_en;
    logic               hit;

    // A load cycle swallows any bit presented alongside it.
    assign shift_en = D_VALID & ~PAT_LOAD;

    shift_reg_n #(
        .N (PAT_LEN)
    ) u_sr (
        .CLK (CLK),
        .RST (RST),
        .EN  (shift_en),
        .D   (D_IN),
        .Q   (hist_q)
    );

    // Next-state compare and update of fill, pattern, mask and counter.
    always_comb begin
        hist_d   = {hist_q[PAT_LEN-2:0], D_IN};
        fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        hit      = shift_en && (fill_inc == FILL_FULL) &&
                   (((hist_d ^ pat_q) & ~mask_q) == '0);

        pat_d   = pat_q;
        mask_d  = mask_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;

        if (PAT_LOAD) begin
            pat_d  = PAT_IN;
            mask_d = MASK_IN;
            fill_d = '0;
            cnt_d  = '0;
        end else if (D_VALID) begin
            // Non-overlapping mode restarts the fill so no bit is reused.
            fill_d  = (hit && !OVERLAP) ? '0 : fill_inc;
            match_d = hit;
            if (hit && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        armed_d = (fill_d == FILL_FULL);
    end

    // State registers; every output comes straight from one of these.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pat_q   <= '0;
            mask_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            armed_q <= armed_d;
        end
    end

    assign MATCH     = match_q;
    assign MATCH_CNT = cnt_q;
    assign ARMED     = armed_q;

endmodule
